// File: rtl/robot_seq_pkg.sv
// Shared types and helpers for the multi-axis robot motion sequencer.
package robot_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_ISSUE,
        S_WAIT,
        S_RETRY,
        S_NEXT,
        S_FINISH,
        S_ERROR
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_FAULT   = 2'd2;
    localparam logic [1:0] ERR_CFG     = 2'd3;

    // Widest axis mask the round-robin picker can handle.
    localparam int MAX_AXIS = 32;

    // Index of the lowest set bit, or -1 when the mask is empty.
    function automatic int lowest_set(input logic [MAX_AXIS-1:0] mask);
        int pos;
        pos = -1;
        for (int i = MAX_AXIS - 1; i >= 0; i--) begin
            if (mask[i]) pos = i;
        end
        return pos;
    endfunction

endpackage

// File: rtl/robot_rr_pick.sv
// Combinational round-robin picker: first set mask bit at or after start_idx,
// searching upward with wrap. wrap flags that the search passed the top axis.
module robot_rr_pick
    import robot_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         mask,
    input  logic [$clog2(N)-1:0] start_idx,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid,
    output logic                 wrap
);
    localparam int             IDX_W = $clog2(N);
    localparam int             PW    = IDX_W + 1;
    localparam logic [PW-1:0]  N_W   = PW'(N);

    logic [MAX_AXIS-1:0] rot;
    logic [PW-1:0]       pos;
    logic [PW-1:0]       sum;
    int                  off;

    // Rotate the mask so bit 0 is start_idx, take the lowest set bit, rotate back.
    always_comb begin
        rot = '0;
        pos = '0;
        for (int i = 0; i < N; i++) begin
            pos = {1'b0, start_idx} + PW'(i);
            if (pos >= N_W) pos = pos - N_W;
            rot[i] = mask[pos[IDX_W-1:0]];
        end
        off   = lowest_set(rot);
        valid = (off >= 0);
        sum   = {1'b0, start_idx} + (valid ? PW'(off) : '0);
        wrap  = valid && (sum >= N_W);
        idx   = wrap ? IDX_W'(sum - N_W) : sum[IDX_W-1:0];
    end

endmodule

// File: rtl/robot_axis_sequencer.sv
// Multi-axis robot motion sequencer: round-robin move commands with watchdog,
// bounded retries, fault supervision and a programmed number of sweeps.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for start; config latched on start
//   SELECT   | choose lowest enabled axis at or after the pointer
//   ISSUE    | one-cycle go_o pulse to the current axis, watchdog cleared
//   WAIT     | waiting for done_i of the current axis, watchdog running
//   RETRY    | watchdog expired; re-issue or give up with timeout error
//   NEXT     | advance pointer, count a sweep on wrap, maybe finish
//   FINISH   | one-cycle done pulse
//   ERROR    | error held with err_code until abort
module robot_axis_sequencer
    import robot_seq_pkg::*;
#(
    parameter int N_AXIS    = 4,
    parameter int CNT_W     = 8,
    parameter int TIMEOUT   = 255,
    parameter int MAX_RETRY = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [N_AXIS-1:0]         axis_en,
    input  logic [CNT_W-1:0]          cycles,
    input  logic [N_AXIS-1:0]         done_i,
    input  logic                      fault_i,
    output logic [N_AXIS-1:0]         go_o,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [1:0]                err_code,
    output logic [$clog2(N_AXIS)-1:0] cur_axis,
    output logic [CNT_W-1:0]          cycle_cnt
);
    localparam int                 IDX_W     = $clog2(N_AXIS);
    localparam int                 WD_W      = $clog2(TIMEOUT + 1);
    localparam int                 RT_W      = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [WD_W-1:0]    WD_LAST   = WD_W'(TIMEOUT - 1);
    localparam logic [RT_W-1:0]    MAX_R     = RT_W'(MAX_RETRY);
    localparam logic [IDX_W-1:0]   LAST_AXIS = IDX_W'(N_AXIS - 1);

    state_e              state_q,     state_d;
    logic [N_AXIS-1:0]   axis_en_q,   axis_en_d;
    logic [CNT_W-1:0]    cycles_q,    cycles_d;
    logic [IDX_W-1:0]    ptr_q,       ptr_d;
    logic [IDX_W-1:0]    cur_axis_q,  cur_axis_d;
    logic [CNT_W-1:0]    cycle_cnt_q, cycle_cnt_d;
    logic [WD_W-1:0]     wd_q,        wd_d;
    logic [RT_W-1:0]     retry_q,     retry_d;
    logic [N_AXIS-1:0]   go_q,        go_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;
    logic                error_q,     error_d;
    logic [1:0]          err_code_q,  err_code_d;

    logic [IDX_W-1:0]    pick_start;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid;
    logic                pick_wrap;
    logic [IDX_W-1:0]    next_start;
    logic                next_wrap;
    logic [CNT_W-1:0]    cnt_inc;

    // Busy covers the states in which a move is being sequenced; FINISH is
    // excluded so busy drops together with the done pulse.
    function automatic logic is_busy(input state_e s);
        return s inside {S_SELECT, S_ISSUE, S_WAIT, S_RETRY, S_NEXT};
    endfunction

    assign next_start = (cur_axis_q == LAST_AXIS) ? '0 : cur_axis_q + IDX_W'(1);
    assign next_wrap  = pick_wrap | (cur_axis_q == LAST_AXIS);
    assign pick_start = (state_q == S_NEXT) ? next_start : ptr_q;
    assign cnt_inc    = cycle_cnt_q + CNT_W'(1);

    robot_rr_pick #(
        .N (N_AXIS)
    ) u_pick (
        .mask      (axis_en_q),
        .start_idx (pick_start),
        .idx       (pick_idx),
        .valid     (pick_valid),
        .wrap      (pick_wrap)
    );

    // Next-state and next-output logic; abort and fault override the case.
    always_comb begin
        state_d     = state_q;
        axis_en_d   = axis_en_q;
        cycles_d    = cycles_q;
        ptr_d       = ptr_q;
        cur_axis_d  = cur_axis_q;
        cycle_cnt_d = cycle_cnt_q;
        wd_d        = wd_q;
        retry_d     = retry_q;
        err_code_d  = err_code_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    axis_en_d   = axis_en;
                    cycles_d    = cycles;
                    cycle_cnt_d = '0;
                    ptr_d       = '0;
                    retry_d     = '0;
                    if (axis_en == '0 || cycles == '0) begin
                        state_d    = S_ERROR;
                        err_code_d = ERR_CFG;
                    end else begin
                        state_d = S_SELECT;
                    end
                end
            end
            S_SELECT: begin
                if (pick_valid) begin
                    cur_axis_d = pick_idx;
                    state_d    = S_ISSUE;
                end else begin
                    state_d    = S_ERROR;
                    err_code_d = ERR_CFG;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wd_d = wd_q + WD_W'(1);
                if (done_i[cur_axis_q]) begin
                    retry_d = '0;
                    state_d = S_NEXT;
                end else if (wd_q == WD_LAST) begin
                    state_d = S_RETRY;
                end
            end
            S_RETRY: begin
                if (retry_q < MAX_R) begin
                    retry_d = retry_q + RT_W'(1);
                    state_d = S_ISSUE;
                end else begin
                    state_d    = S_ERROR;
                    err_code_d = ERR_TIMEOUT;
                end
            end
            S_NEXT: begin
                ptr_d   = pick_idx;
                state_d = S_SELECT;
                if (next_wrap) begin
                    cycle_cnt_d = cnt_inc;
                    if (cnt_inc == cycles_q) state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_IDLE;
        endcase

        if (fault_i && is_busy(state_q)) begin
            state_d    = S_ERROR;
            err_code_d = ERR_FAULT;
        end

        if (abort) begin
            state_d    = S_IDLE;
            err_code_d = ERR_NONE;
        end

        go_d = '0;
        if (state_d == S_ISSUE) go_d[cur_axis_d] = 1'b1;
        busy_d  = is_busy(state_d);
        done_d  = (state_d == S_FINISH);
        error_d = (state_d == S_ERROR);
    end

    // State, latched config, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            axis_en_q   <= '0;
            cycles_q    <= '0;
            ptr_q       <= '0;
            cur_axis_q  <= '0;
            cycle_cnt_q <= '0;
            wd_q        <= '0;
            retry_q     <= '0;
            go_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            axis_en_q   <= axis_en_d;
            cycles_q    <= cycles_d;
            ptr_q       <= ptr_d;
            cur_axis_q  <= cur_axis_d;
            cycle_cnt_q <= cycle_cnt_d;
            wd_q        <= wd_d;
            retry_q     <= retry_d;
            go_q        <= go_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
        end
    end

    assign go_o      = go_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_code  = err_code_q;
    assign cur_axis  = cur_axis_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_robot_axis_sequencer.sv
// Scoreboard bench for robot_axis_sequencer: stimulus pushes expected output
// events (go_o pulse, done pulse, error entry) with their cycle spacing; a
// monitor pops and compares whenever the DUT presents one.
module tb_robot_axis_sequencer;
    localparam int N_AXIS    = 4;
    localparam int CNT_W     = 8;
    localparam int TIMEOUT   = 8;
    localparam int MAX_RETRY = 3;

    localparam int EV_GO   = 0;
    localparam int EV_DONE = 1;
    localparam int EV_ERR  = 2;

    logic              clk = 1'b0;
    logic              rst, start, abort, fault_i;
    logic [3:0]        axis_en, done_i, go_o, man_done, resp_done;
    logic [7:0]        cycles, cycle_cnt;
    logic              busy, done, error;
    logic [1:0]        err_code, cur_axis;

    typedef struct {
        int kind;
        int data;
        int gap;
    } ev_t;

    ev_t exp_q[$];
    int  n_vec = 0;
    int  n_bad = 0;
    int  cyc = 0;
    int  start_cyc = 0;
    int  last_ev_cyc = 0;
    bit  mon_en = 1'b0;
    bit  resp_en = 1'b0;
    bit  err_prev = 1'b0;
    bit  ok;
    ev_t mon_e;
    int  mon_k, mon_d, mon_ref;
    logic [3:0] resp_ax;

    assign done_i = man_done | resp_done;

    robot_axis_sequencer #(
        .N_AXIS    (N_AXIS),
        .CNT_W     (CNT_W),
        .TIMEOUT   (TIMEOUT),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .axis_en   (axis_en),
        .cycles    (cycles),
        .done_i    (done_i),
        .fault_i   (fault_i),
        .go_o      (go_o),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_code  (err_code),
        .cur_axis  (cur_axis),
        .cycle_cnt (cycle_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input int data, input int gap);
        ev_t e;
        e.kind = kind;
        e.data = data;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    task automatic do_start(input logic [3:0] en, input logic [7:0] n);
        @(posedge clk); #1;
        axis_en   = en;
        cycles    = n;
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_abort();
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
    endtask

    task automatic wait_go(input string name, output bit found);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (go_o != 4'b0) found = 1'b1;
        end
        if (!found) check({name, "_go_timeout"}, 0, 1);
    endtask

    task automatic drain(input string name, input int budget);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            @(negedge clk);
            i++;
        end
        check({name, "_pending_events"}, exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_go_o"},      int'(go_o),      0);
        check({name, "_busy"},      int'(busy),      0);
        check({name, "_done"},      int'(done),      0);
        check({name, "_error"},     int'(error),     0);
        check({name, "_err_code"},  int'(err_code),  0);
        check({name, "_cur_axis"},  int'(cur_axis),  0);
        check({name, "_cycle_cnt"}, int'(cycle_cnt), 0);
    endtask

    // Monitor: every output event is matched against the head of the queue.
    initial begin
        wait (mon_en);
        forever begin
            @(negedge clk);
            mon_k = -1;
            mon_d = 0;
            if (go_o != 4'b0) begin
                mon_k = EV_GO;
                mon_d = int'(go_o);
            end else if (done) begin
                mon_k = EV_DONE;
                mon_d = int'(cycle_cnt);
                check("done_busy_low", int'(busy), 0);
            end else if (error && !err_prev) begin
                mon_k = EV_ERR;
                mon_d = int'(err_code);
            end
            err_prev = error;
            if (mon_k >= 0) begin
                mon_ref = (start_cyc > last_ev_cyc) ? start_cyc : last_ev_cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_event_kind", mon_k, -1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ev_kind", mon_k, mon_e.kind);
                    check("ev_data", mon_d, mon_e.data);
                    if (mon_e.gap >= 0) check("ev_gap", cyc - mon_ref, mon_e.gap);
                end
                last_ev_cyc = cyc;
            end
        end
    end

    // Auto-responder: answers each go_o with done_i three cycles later.
    initial begin
        resp_done = 4'b0;
        forever begin
            @(negedge clk);
            if (resp_en && go_o != 4'b0) begin
                resp_ax = go_o;
                repeat (3) @(posedge clk);
                #1 resp_done = resp_ax;
                @(posedge clk);
                #1 resp_done = 4'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        fault_i  = 1'b0;
        axis_en  = 4'b0;
        cycles   = 8'd0;
        man_done = 4'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        mon_en = 1'b1;

        // 1: two sweeps over axes 0,1,3 with prompt answers
        resp_en = 1'b1;
        expect_ev(EV_GO, 1, 2);
        expect_ev(EV_GO, 2, 6);
        expect_ev(EV_GO, 8, 6);
        expect_ev(EV_GO, 1, 6);
        expect_ev(EV_GO, 2, 6);
        expect_ev(EV_GO, 8, 6);
        expect_ev(EV_DONE, 2, 5);
        do_start(4'b1011, 8'd2);
        drain("t1", 200);
        resp_en = 1'b0;

        // 2: axis 0 never answers -> 4 attempts 10 cycles apart, then timeout
        expect_ev(EV_GO, 1, 2);
        expect_ev(EV_GO, 1, 10);
        expect_ev(EV_GO, 1, 10);
        expect_ev(EV_GO, 1, 10);
        expect_ev(EV_ERR, 1, 10);
        do_start(4'b0001, 8'd1);
        drain("t2", 200);
        check("t2_error_held", int'(error), 1);
        check("t2_err_code_held", int'(err_code), 1);
        do_abort();
        @(negedge clk);
        check("t2_abort_error", int'(error), 0);
        check("t2_abort_err_code", int'(err_code), 0);
        check("t2_abort_busy", int'(busy), 0);

        // 3: fault and done on the same WAIT cycle -> fault wins
        expect_ev(EV_GO, 1, 2);
        expect_ev(EV_ERR, 2, 2);
        do_start(4'b0001, 8'd3);
        wait_go("t3", ok);
        @(posedge clk); #1;
        fault_i  = 1'b1;
        man_done = 4'b0001;
        @(posedge clk); #1;
        fault_i  = 1'b0;
        man_done = 4'b0;
        drain("t3", 50);
        repeat (20) @(negedge clk);
        check("t3_err_code", int'(err_code), 2);
        check("t3_go_quiet", int'(go_o), 0);
        do_abort();

        // 4: empty axis mask -> config error one cycle after start
        expect_ev(EV_ERR, 3, 1);
        do_start(4'b0000, 8'd5);
        drain("t4", 50);
        check("t4_error", int'(error), 1);
        do_abort();

        // 5: reset during WAIT on axis 2, then a normal single-axis run
        expect_ev(EV_GO, 4, 2);
        do_start(4'b0100, 8'd1);
        wait_go("t5", ok);
        check("t5_cur_axis", int'(cur_axis), 2);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("t5_rst");
        resp_en = 1'b1;
        expect_ev(EV_GO, 4, 2);
        expect_ev(EV_DONE, 1, 5);
        do_start(4'b0100, 8'd1);
        drain("t5", 100);
        resp_en = 1'b0;

        // 6: stray done_i[3], second start and config change ignored in WAIT on axis 1
        expect_ev(EV_GO, 1, 2);
        expect_ev(EV_GO, 2, 4);
        expect_ev(EV_GO, 8, 6);
        expect_ev(EV_DONE, 1, 3);
        do_start(4'b1011, 8'd1);
        wait_go("t6a", ok);
        @(posedge clk); #1 man_done = 4'b0001;
        @(posedge clk); #1 man_done = 4'b0;
        wait_go("t6b", ok);
        @(posedge clk); #1;
        man_done = 4'b1000;
        start    = 1'b1;
        axis_en  = 4'b1111;
        cycles   = 8'd0;
        @(posedge clk); #1;
        man_done = 4'b0;
        start    = 1'b0;
        @(posedge clk); #1 man_done = 4'b0010;
        @(posedge clk); #1 man_done = 4'b0;
        wait_go("t6c", ok);
        @(posedge clk); #1 man_done = 4'b1000;
        @(posedge clk); #1 man_done = 4'b0;
        drain("t6", 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
